// File: rtl/dab_mod_scheduler.sv
// dab_mod_scheduler: validates host t1/t2/phi/fs settings, commits them on switching-period
// boundaries, slews phi for soft start/stop and forces zero drive on fault or watchdog timeout.
module dab_mod_scheduler #(
    parameter logic signed [8:0] PHI_STEP  = 9'sd4,
    parameter logic signed [8:0] PHI_MAX   = 9'sd128,
    parameter logic [17:0]       FS_MIN    = 18'd10000,
    parameter logic [17:0]       FS_MAX    = 18'd200000,
    parameter logic [19:0]       WD_CYCLES = 20'd100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fault,
    input  logic              period_end,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic signed [8:0] t1_in,
    input  logic signed [8:0] t2_in,
    input  logic signed [8:0] phi_in,
    input  logic [17:0]       fs_in,
    output logic              cfg_err,
    output logic signed [8:0] t1,
    output logic signed [8:0] t2,
    output logic signed [8:0] phi,
    output logic [17:0]       fs_DAB,
    output logic              sync,
    output logic              run,
    output logic [1:0]        status
);
    localparam logic [2:0] IDLE = 3'd0, SYNC = 3'd1, RUN = 3'd2, DRAIN = 3'd3, FAULT = 3'd4;
    localparam logic signed [9:0] STP = {PHI_STEP[8], PHI_STEP};

    logic [2:0]        state_q, state_d;
    logic signed [8:0] t1_q, t1_d, t2_q, t2_d, phi_q, phi_d;
    logic signed [8:0] sh_t1_q, sh_t1_d, sh_t2_q, sh_t2_d, sh_phi_q, sh_phi_d;
    logic [17:0]       fs_q, fs_d, sh_fs_q, sh_fs_d;
    logic              sh_valid_q, sh_valid_d, pend_q, pend_d, err_q, err_d;
    logic [19:0]       wd_q, wd_d;
    logic [1:0]        status_q, status_d;
    logic              cfg_ok, accept, in_mod, wd_hit;
    logic signed [8:0] tgt, phi_nxt;
    logic signed [9:0] d;

    assign cfg_ready = state_q != FAULT;
    assign cfg_ok    = !t1_in[8] && !t2_in[8] && phi_in <= PHI_MAX && phi_in >= -PHI_MAX
                       && fs_in >= FS_MIN && fs_in <= FS_MAX;
    assign accept    = cfg_valid && cfg_ready && cfg_ok;
    assign in_mod    = state_q == RUN || state_q == DRAIN;
    assign wd_hit    = in_mod && !period_end && wd_q == WD_CYCLES - 20'd1;
    // Slew in 10 bits so the difference of two extreme 9-bit phases cannot wrap
    assign tgt       = state_q == DRAIN ? 9'sd0 : sh_phi_q;
    assign d         = {tgt[8], tgt} - {phi_q[8], phi_q};
    assign phi_nxt   = d > STP ? phi_q + PHI_STEP : d < -STP ? phi_q - PHI_STEP : tgt;

    assign t1      = t1_q;
    assign t2      = t2_q;
    assign phi     = phi_q;
    assign fs_DAB  = fs_q;
    assign sync    = state_q == SYNC;
    assign run     = in_mod || state_q == SYNC;
    assign status  = status_q;
    assign cfg_err = err_q;

    always_comb begin
        state_d    = state_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        phi_d      = phi_q;
        fs_d       = fs_q;
        sh_t1_d    = accept ? t1_in : sh_t1_q;
        sh_t2_d    = accept ? t2_in : sh_t2_q;
        sh_phi_d   = accept ? phi_in : sh_phi_q;
        sh_fs_d    = accept ? fs_in : sh_fs_q;
        sh_valid_d = sh_valid_q | accept;
        pend_d     = pend_q | accept;
        wd_d       = wd_q;
        status_d   = status_q;
        err_d      = cfg_valid && cfg_ready && !cfg_ok;
        if (fault || wd_hit) begin
            state_d  = FAULT;
            t1_d     = '0;
            t2_d     = '0;
            phi_d    = '0;
            status_d = status_q | {wd_hit & ~fault, fault};
        end else begin
            case (state_q)
                IDLE: if (enable && sh_valid_q) begin
                    state_d = SYNC;
                    t1_d    = sh_t1_q;
                    t2_d    = sh_t2_q;
                    fs_d    = sh_fs_q;
                    phi_d   = '0;
                    pend_d  = accept;
                    wd_d    = '0;
                end
                SYNC: state_d = RUN;
                RUN, DRAIN: begin
                    wd_d = period_end ? 20'd0 : wd_q + 20'd1;
                    // Commit reads the registered shadow, so a same-cycle accept stays pending
                    if (period_end) begin
                        phi_d = phi_nxt;
                        if (pend_q) begin
                            t1_d   = sh_t1_q;
                            t2_d   = sh_t2_q;
                            fs_d   = sh_fs_q;
                            pend_d = accept;
                        end
                    end
                    if (state_q == RUN) state_d = enable ? RUN : DRAIN;
                    else if (period_end && phi_nxt == 9'sd0) state_d = IDLE;
                    else if (enable) state_d = RUN;
                end
                FAULT: if (!enable) begin
                    state_d  = IDLE;
                    status_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            t1_q       <= '0;
            t2_q       <= '0;
            phi_q      <= '0;
            fs_q       <= FS_MIN;
            sh_t1_q    <= '0;
            sh_t2_q    <= '0;
            sh_phi_q   <= '0;
            sh_fs_q    <= FS_MIN;
            sh_valid_q <= 1'b0;
            pend_q     <= 1'b0;
            wd_q       <= '0;
            status_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            phi_q      <= phi_d;
            fs_q       <= fs_d;
            sh_t1_q    <= sh_t1_d;
            sh_t2_q    <= sh_t2_d;
            sh_phi_q   <= sh_phi_d;
            sh_fs_q    <= sh_fs_d;
            sh_valid_q <= sh_valid_d;
            pend_q     <= pend_d;
            wd_q       <= wd_d;
            status_q   <= status_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_dab_mod_scheduler.sv
// tb_dab_mod_scheduler: randomized scenario bench; expected phi follows a per-boundary slew model.
module tb_dab_mod_scheduler;
    localparam int WD = 300;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, fault = 1'b0, period_end = 1'b0, cfg_valid = 1'b0;
    logic cfg_ready, cfg_err, sync, run;
    logic [1:0] status;
    logic signed [8:0] t1_in = '0, t2_in = '0, phi_in = '0, t1, t2, phi;
    logic [17:0] fs_in = '0, fs_DAB;
    int checks = 0, errors = 0;
    int T1, T2, P, F, A, B, C, Q, X, nfs, ep, n;
    bit done;

    dab_mod_scheduler #(.WD_CYCLES(20'(WD))) dut (
        .clk(clk), .rst(rst), .enable(enable), .fault(fault), .period_end(period_end),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .t1_in(t1_in), .t2_in(t2_in),
        .phi_in(phi_in), .fs_in(fs_in), .cfg_err(cfg_err), .t1(t1), .t2(t2), .phi(phi),
        .fs_DAB(fs_DAB), .sync(sync), .run(run), .status(status)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int slew(input int cur, input int tgt);
        int dd = tgt - cur;
        if (dd <= 4 && dd >= -4) return tgt;
        return dd > 0 ? cur + 4 : cur - 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input int a, input int b, input int p, input int f);
        cfg_valid = 1'b1;
        t1_in = 9'(a);
        t2_in = 9'(b);
        phi_in = 9'(p);
        fs_in = 18'(f);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_pe(input int gap);
        repeat (gap) tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_t1", int'(t1), 0);
        chk("rst_t2", int'(t2), 0);
        chk("rst_phi", int'(phi), 0);
        chk("rst_fs", int'(fs_DAB), 10000);
        chk("rst_sync", sync, 0);
        chk("rst_run", run, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_status", int'(status), 0);
        rst = 1'b0;
        tick();

        T1 = $urandom_range(255, 70);
        T2 = $urandom_range(255, 0);
        P = $urandom_range(128, 5);
        F = $urandom_range(200000, 10000);
        send_cfg(T1, T2, P, F);
        chk("cfg_ok_err", cfg_err, 0);
        enable = 1'b1;
        tick();
        chk("sync_pulse", sync, 1);
        chk("sync_run", run, 1);
        chk("sync_t1", int'(t1), T1);
        chk("sync_t2", int'(t2), T2);
        chk("sync_fs", int'(fs_DAB), F);
        chk("sync_phi", int'(phi), 0);
        tick();
        chk("sync_once", sync, 0);
        ep = 0;
        for (int k = 0; k < 40; k++) begin
            pulse_pe($urandom_range(3, 0));
            ep = slew(ep, P);
            chk("ramp_phi", int'(phi), ep);
        end

        send_cfg(60, T2, P, F);
        chk("mid_t1_hold", int'(t1), T1);
        repeat (2) tick();
        chk("pre_boundary_t1", int'(t1), T1);
        pulse_pe(0);
        chk("boundary_t1", int'(t1), 60);
        A = $urandom_range(127, 0);
        B = A + 128;
        send_cfg(A, T2, P, F);
        send_cfg(B, T2, P, F);
        pulse_pe(1);
        chk("double_cfg_t1", int'(t1), B);
        C = 255 - B;
        cfg_valid = 1'b1;
        t1_in = 9'(C);
        period_end = 1'b1;
        tick();
        cfg_valid = 1'b0;
        period_end = 1'b0;
        chk("simul_t1", int'(t1), B);
        pulse_pe(1);
        chk("simul_next_t1", int'(t1), C);
        Q = int'($urandom_range(256, 0)) - 128;
        send_cfg(C, T2, Q, F);
        for (int k = 0; k < 70; k++) begin
            pulse_pe($urandom_range(2, 0));
            ep = slew(ep, Q);
            chk("retarget_phi", int'(phi), ep);
        end

        for (int i = 0; i < 5; i++) begin
            case (i)
                0: send_cfg(-1, T2, Q, F);
                1: send_cfg(C, T2, 130, F);
                2: send_cfg(C, T2, Q, 5000);
                3: send_cfg(C, T2, -129, F);
                default: send_cfg(C, T2, Q, 200001);
            endcase
            chk("rej_err", cfg_err, 1);
            tick();
            chk("rej_err_clear", cfg_err, 0);
            chk("rej_t1", int'(t1), C);
        end
        pulse_pe(0);
        chk("rej_boundary_t1", int'(t1), C);
        chk("rej_boundary_fs", int'(fs_DAB), F);
        chk("rej_boundary_phi", int'(phi), Q);
        send_cfg(C, T2, Q, 200000);
        chk("fsmax_err", cfg_err, 0);
        pulse_pe(0);
        chk("fsmax_fs", int'(fs_DAB), 200000);

        enable = 1'b0;
        tick();
        chk("drain_run", run, 1);
        done = 1'b0;
        for (int k = 0; k < 70 && !done; k++) begin
            pulse_pe($urandom_range(2, 0));
            ep = slew(ep, 0);
            chk("drain_phi", int'(phi), ep);
            chk("drain_run_level", run, int'(ep != 0));
            done = ep == 0;
        end
        chk("stop_sync", sync, 0);

        send_cfg(C, T2, P, F);
        enable = 1'b1;
        tick();
        chk("restart_sync", sync, 1);
        chk("restart_fs", int'(fs_DAB), F);
        tick();
        ep = 0;
        repeat (3) begin
            pulse_pe(0);
            ep = slew(ep, P);
            chk("restart_phi", int'(phi), ep);
        end
        enable = 1'b0;
        tick();
        pulse_pe(0);
        ep = slew(ep, 0);
        chk("partial_drain_phi", int'(phi), ep);
        enable = 1'b1;
        tick();
        chk("reenter_sync", sync, 0);
        chk("reenter_run", run, 1);
        pulse_pe(0);
        ep = slew(ep, P);
        chk("reenter_phi", int'(phi), ep);

        X = $urandom_range(255, 0);
        nfs = F == 50000 ? 60000 : 50000;
        send_cfg(X, T2, P, nfs);
        fault = 1'b1;
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        chk("fault_t1", int'(t1), 0);
        chk("fault_t2", int'(t2), 0);
        chk("fault_phi", int'(phi), 0);
        chk("fault_status", int'(status), 1);
        chk("fault_run", run, 0);
        chk("fault_sync", sync, 0);
        chk("fault_fs_no_commit", int'(fs_DAB), F);
        chk("fault_ready", cfg_ready, 0);
        fault = 1'b0;
        repeat (3) tick();
        chk("fault_hold_status", int'(status), 1);
        chk("fault_hold_run", run, 0);
        chk("fault_hold_ready", cfg_ready, 0);
        enable = 1'b0;
        tick();
        chk("fault_exit_status", int'(status), 0);
        chk("fault_exit_ready", cfg_ready, 1);
        enable = 1'b1;
        tick();
        chk("resync_pulse", sync, 1);
        chk("resync_t1", int'(t1), X);
        chk("resync_fs", int'(fs_DAB), nfs);
        tick();

        pulse_pe(0);
        n = 0;
        while (run && n < WD + 100) begin
            tick();
            n++;
        end
        chk("wd_cycles", n, WD);
        chk("wd_status", int'(status), 2);
        chk("wd_t1", int'(t1), 0);
        chk("wd_phi", int'(phi), 0);
        enable = 1'b0;
        tick();
        chk("wd_exit_status", int'(status), 0);

        enable = 1'b1;
        repeat (2) tick();
        pulse_pe(0);
        pulse_pe(0);
        chk("pre_arst_phi", int'(phi), slew(slew(0, P), P));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_t1", int'(t1), 0);
        chk("arst_phi", int'(phi), 0);
        chk("arst_fs", int'(fs_DAB), 10000);
        chk("arst_run", run, 0);
        chk("arst_status", int'(status), 0);
        chk("arst_ready", cfg_ready, 1);
        #2;
        rst = 1'b0;
        repeat (3) tick();
        chk("post_arst_idle", run, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
